// File: rtl/rv_ctrl_fsm_pkg.sv
// Shared types and constants for the RV32I multi-cycle control FSM.
// Holds the state encoding, opcode values, datapath select encodings and instruction classes.
package rv_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_IMM = 2'd1, PC_ALU = 2'd2} pc_sel_e;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} wb_sel_e;
  typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2} alu_a_sel_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  // One-hot instruction class; nop covers FENCE, SYSTEM and illegal encodings.
  typedef struct packed {
    logic op;
    logic op_imm;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic nop;
  } instr_cls_t;

endpackage

// File: rtl/rv_ctrl_fsm_decode.sv
// Combinational instruction decode: class one-hot, rd==0, illegal flag and ALU operation.
module rv_ctrl_fsm_decode
  import rv_ctrl_fsm_pkg::*;
(
  input  logic [31:0] instr,
  output instr_cls_t  cls,
  output logic        rd_zero,
  output logic        illegal,
  output logic [3:0]  alu_op
);

  logic [2:0] funct3;
  logic       alt;
  logic       unused_instr;

  assign funct3       = instr[14:12];
  assign alt          = instr[30];
  assign rd_zero      = (instr[11:7] == 5'd0);
  assign unused_instr = ^{instr[31], instr[29:15]};

  always_comb begin
    cls     = '0;
    illegal = 1'b0;
    alu_op  = ALU_ADD;
    unique case (instr[6:0])
      OPC_OP: begin
        cls.op = 1'b1;
        alu_op = {alt, funct3};
      end
      OPC_OP_IMM: begin
        cls.op_imm = 1'b1;
        // Only the shift-right immediate uses bit 30 as an opcode bit; elsewhere it is immediate.
        alu_op     = {(funct3 == 3'b101) & alt, funct3};
      end
      OPC_LOAD:   cls.load  = 1'b1;
      OPC_STORE:  cls.store = 1'b1;
      OPC_BRANCH: begin
        cls.branch = 1'b1;
        alu_op     = ALU_SUB;
      end
      OPC_JAL:    cls.jal   = 1'b1;
      OPC_JALR:   cls.jalr  = 1'b1;
      OPC_LUI:    cls.lui   = 1'b1;
      OPC_AUIPC:  cls.auipc = 1'b1;
      OPC_FENCE, OPC_SYSTEM: cls.nop = 1'b1;
      default: begin
        cls.nop = 1'b1;
        illegal = 1'b1;
      end
    endcase
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/rv_ctrl_fsm.sv
// Multi-cycle RV32I control FSM driving datapath selects and strobes over one memory port.
// Define CTRL_TRAP_EN to send illegal instructions to a sticky TRAP state instead of a NOP.
//
// state  | meaning
// RST    | post-reset / post-timeout, all outputs idle
// FETCH  | instruction request on PC, IR latched on mem_ready
// DECODE | regfile read, no strobes
// EXEC   | ALU operation; branches resolve and return to FETCH
// MEM    | load/store request on ALU address
// WB     | regfile write and PC update
// TRAP   | illegal instruction seen, idle until reset
module rv_ctrl_fsm
  import rv_ctrl_fsm_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 0
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [3:0]  alu_op,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic        bus_err,
  output logic [2:0]  state_o
);

  state_e     state_q, state_d;
  instr_cls_t cls;
  logic       rd_zero, illegal, bus_timeout, bus_err_q;
  logic [3:0] dec_alu_op;
  logic       unused_cls;

  rv_ctrl_fsm_decode u_decode (
    .instr   (instr),
    .cls     (cls),
    .rd_zero (rd_zero),
    .illegal (illegal),
    .alu_op  (dec_alu_op)
  );

  assign unused_cls = cls.op_imm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus_timeout) bus_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RST:   state_d = ST_FETCH;
      ST_FETCH: if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        state_d = ST_EXEC;
`ifdef CTRL_TRAP_EN
        if (illegal) state_d = ST_TRAP;
`endif
      end
      ST_EXEC: begin
        if (cls.load || cls.store) state_d = ST_MEM;
        else if (cls.branch)       state_d = ST_FETCH;
        else                       state_d = ST_WB;
      end
      ST_MEM:  if (mem_ready) state_d = cls.store ? ST_FETCH : ST_WB;
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_RST;
    endcase
    if (bus_timeout) state_d = ST_RST;
  end

  always_comb begin
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_a_sel    = A_RS1;
    alu_b_sel    = 1'b0;
    alu_op       = ALU_ADD;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    // Operand selects stay put from EXEC to WB so the ALU result is stable at the write.
    if (state_q inside {ST_EXEC, ST_MEM, ST_WB}) begin
      if (cls.auipc || cls.jal) alu_a_sel = A_PC;
      else if (cls.lui)         alu_a_sel = A_ZERO;
      alu_b_sel = !(cls.op || cls.branch);
      alu_op    = dec_alu_op;
    end
    unique case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      ST_EXEC: begin
        if (cls.branch) begin
          pc_we  = 1'b1;
          pc_sel = br_taken ? PC_IMM : PC_PLUS4;
        end
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = cls.store;
        pc_we        = mem_ready && cls.store;
      end
      ST_WB: begin
        pc_we = 1'b1;
        rf_we = !cls.nop && !rd_zero;
        if (cls.jal)       pc_sel = PC_IMM;
        else if (cls.jalr) pc_sel = PC_ALU;
        if (cls.load)                  wb_sel = WB_MEM;
        else if (cls.jal || cls.jalr)  wb_sel = WB_PC4;
      end
      default: ;
    endcase
  end

  generate
    if (BUS_TIMEOUT > 0) begin : g_timeout
      localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
      logic [CW-1:0] wait_q, wait_d;

      // Fires on the BUS_TIMEOUT-th consecutive stalled cycle of a request.
      assign bus_timeout = mem_req && !mem_ready && (wait_q == CW'(BUS_TIMEOUT - 1));

      always_comb begin
        wait_d = '0;
        if (mem_req && !mem_ready && !bus_timeout) wait_d = wait_q + CW'(1);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_q <= '0;
        else        wait_q <= wait_d;
      end
    end else begin : g_no_timeout
      assign bus_timeout = 1'b0;
    end
  endgenerate

`ifdef CTRL_TRAP_EN
  logic trap_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    trap_q <= 1'b0;
    else if (state_d == ST_TRAP)   trap_q <= 1'b1;
  end
  assign trap = trap_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal;
  assign trap           = 1'b0;
`endif

  assign bus_err = bus_err_q;
  assign state_o = state_q;

endmodule
